// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC result buffer slice.
// DUE beats are flagged with decode_result_t and optionally replaced by POISON_PATTERN.
package ecc_pkg;

  typedef enum logic {
    NE_CE = 1'b0,
    DUE   = 1'b1
  } decode_result_t;

  localparam logic [63:0] POISON_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF;

endpackage

// File: rtl/ecc_result_buffer_if.sv
// Producer/consumer handshake bundle for ecc_result_buffer.
// The slave modport is the buffer; the master modport is the surrounding read path.
interface ecc_result_buffer_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              decode_result_in;
  logic [DATA_W-1:0] data_in;
  logic [TAG_W-1:0]  tag_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_due;
  logic [TAG_W-1:0]  out_tag;

  modport slave (
    input  in_valid, decode_result_in, data_in, tag_in, out_ready,
    output in_ready, out_valid, out_data, out_due, out_tag
  );

  modport master (
    output in_valid, decode_result_in, data_in, tag_in, out_ready,
    input  in_ready, out_valid, out_data, out_due, out_tag
  );
endinterface

// File: rtl/ecc_sync_fifo.sv
// Generic synchronous FIFO with registered occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module ecc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ecc_result_buffer.sv
// Buffers decoder results {due, tag, data} in a FIFO, poisons DUE data on the
// read side and keeps saturating CE/DUE statistics with a last-DUE tag log.
module ecc_result_buffer
  import ecc_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16,
  parameter int POISON_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  ecc_result_buffer_if.slave  bus,
  input  logic                clr_stats,
  output logic [CNT_W-1:0]    beat_count,
  output logic [CNT_W-1:0]    due_count,
  output logic                due_seen,
  output logic [TAG_W-1:0]    last_due_tag
);
  localparam int ENTRY_W = 1 + TAG_W + DATA_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] poison_sel(input logic due, input logic [DATA_W-1:0] d);
    return (due && (POISON_EN != 0)) ? POISON_PATTERN[DATA_W-1:0] : d;
  endfunction

  decode_result_t     in_res;
  logic               in_due;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] hold_entry;
  logic [ENTRY_W-1:0] shown_entry;

  assign in_res   = decode_result_t'(bus.decode_result_in);
  assign in_due   = (in_res == DUE);
  assign push     = bus.in_valid && !full;
  assign pop      = bus.out_ready && !empty;
  assign wr_entry = {in_due, bus.tag_in, bus.data_in};

  ecc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head_entry),
    .full    (full),
    .empty   (empty)
  );

  // When empty the outputs show the last entry handed out, not a stale slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   hold_entry <= '0;
    else if (pop) hold_entry <= head_entry;
  end

  assign shown_entry   = empty ? hold_entry : head_entry;
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_due   = shown_entry[ENTRY_W-1];
  assign bus.out_tag   = shown_entry[DATA_W +: TAG_W];
  assign bus.out_data  = poison_sel(shown_entry[ENTRY_W-1], shown_entry[DATA_W-1:0]);

  // A clear coinciding with a push restarts the statistics from that push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count   <= '0;
      due_count    <= '0;
      due_seen     <= 1'b0;
      last_due_tag <= '0;
    end else if (clr_stats) begin
      beat_count   <= push ? CNT_W'(1) : '0;
      due_count    <= (push && in_due) ? CNT_W'(1) : '0;
      due_seen     <= push && in_due;
      last_due_tag <= (push && in_due) ? bus.tag_in : '0;
    end else if (push) begin
      beat_count <= sat_inc(beat_count);
      if (in_due) begin
        due_count    <= sat_inc(due_count);
        due_seen     <= 1'b1;
        last_due_tag <= bus.tag_in;
      end
    end
  end

endmodule

// File: tb/tb_ecc_result_buffer.sv
// Scoreboard bench for ecc_result_buffer: a driver queues expected beats on
// acceptance, a monitor pops and compares whenever the consumer takes a beat.
module tb_ecc_result_buffer;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int MAXC   = (1 << CNT_W) - 1;
  localparam logic [63:0] POISON = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct {
    logic        due;
    logic [7:0]  tag;
    logic [63:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] beat_count;
  logic [CNT_W-1:0] due_count;
  logic             due_seen;
  logic [TAG_W-1:0] last_due_tag;

  ecc_result_buffer_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  ecc_result_buffer #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .POISON_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clr_stats(clr_stats),
    .beat_count(beat_count), .due_count(due_count),
    .due_seen(due_seen), .last_due_tag(last_due_tag)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ready_mode = 0;
  int   m_beats = 0;
  int   m_dues  = 0;
  logic m_seen  = 1'b0;
  logic [7:0] m_tag = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_stats(input string name);
    check({name, "_beat_count"}, 64'(beat_count), 64'(m_beats));
    check({name, "_due_count"}, 64'(due_count), 64'(m_dues));
    check({name, "_due_seen"}, 64'(due_seen), 64'(m_seen));
    check({name, "_last_due_tag"}, 64'(last_due_tag), 64'(m_tag));
  endtask

  function automatic void model_clear();
    m_beats = 0;
    m_dues  = 0;
    m_seen  = 1'b0;
    m_tag   = '0;
  endfunction

  function automatic void model_accept(input logic due, input logic [63:0] data,
                                       input logic [7:0] tag, input logic clr);
    exp_t e;
    if (clr) model_clear();
    if (m_beats < MAXC) m_beats++;
    if (due) begin
      if (m_dues < MAXC) m_dues++;
      m_seen = 1'b1;
      m_tag  = tag;
    end
    e.due  = due;
    e.tag  = tag;
    e.data = due ? POISON : data;
    exp_q.push_back(e);
  endfunction

  // Consumer: out_ready policy applied one step after each rising edge.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every beat the consumer takes must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 64'(bus.out_tag), 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pop_due", 64'(bus.out_due), 64'(e.due));
          check("pop_tag", 64'(bus.out_tag), 64'(e.tag));
          check("pop_data", bus.out_data, e.data);
        end
      end
    end
  end

  task automatic set_ready(input int m);
    ready_mode = m;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic due, input logic [63:0] data, input logic [7:0] tag,
                       input logic clr);
    bus.in_valid         = 1'b1;
    bus.decode_result_in = due;
    bus.data_in          = data;
    bus.tag_in           = tag;
    clr_stats            = clr;
  endtask

  task automatic wait_accept(input logic due, input logic [63:0] data, input logic [7:0] tag,
                             input logic clr);
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept(due, data, tag, clr);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    clr_stats    = 1'b0;
  endtask

  task automatic push_beat(input logic due, input logic [63:0] data, input logic [7:0] tag,
                           input logic clr);
    drive(due, data, tag, clr);
    wait_accept(due, data, tag, clr);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++)
      push_beat(1'($urandom_range(0, 3) == 0), {$urandom, $urandom}, 8'($urandom), 1'b0);
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_drain_timeout"}, 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    check({name, "_empty_after_drain"}, 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    logic [63:0] d;
    exp_t        head;
    bus.in_valid = 1'b0;
    bus.decode_result_in = 1'b0;
    bus.data_in = '0;
    bus.tag_in  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_data", bus.out_data, 64'(0));
    check_stats("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single NE/CE beat, no bypass, visible one cycle after acceptance
    drive(1'b0, 64'h0123_4567_89AB_CDEF, 8'h05, 1'b0);
    @(negedge clk);
    check("t1_no_bypass", 64'(bus.out_valid), 64'(0));
    model_accept(1'b0, 64'h0123_4567_89AB_CDEF, 8'h05, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t1_out_valid", 64'(bus.out_valid), 64'(1));
    check("t1_out_data", bus.out_data, 64'h0123_4567_89AB_CDEF);
    check("t1_out_tag", 64'(bus.out_tag), 64'h05);
    check("t1_beat_count", 64'(beat_count), 64'(1));
    check("t1_due_count", 64'(due_count), 64'(0));
    set_ready(1);
    drain("t1");

    // 2: DUE beat is poisoned; empty outputs hold the last popped beat
    set_ready(0);
    push_beat(1'b1, 64'h1111_2222_3333_4444, 8'h3C, 1'b0);
    @(negedge clk);
    check("t2_out_due", 64'(bus.out_due), 64'(1));
    check("t2_out_data", bus.out_data, POISON);
    check("t2_due_count", 64'(due_count), 64'(1));
    check("t2_due_seen", 64'(due_seen), 64'(1));
    check("t2_last_due_tag", 64'(last_due_tag), 64'h3C);
    set_ready(1);
    drain("t2");
    check("t2_hold_due", 64'(bus.out_due), 64'(1));
    check("t2_hold_data", bus.out_data, POISON);
    check("t2_hold_tag", 64'(bus.out_tag), 64'h3C);

    // 3: fill with consumer stalled, fifth beat held until release
    set_ready(0);
    push_rand(DEPTH);
    @(negedge clk);
    check("t3_full_in_ready", 64'(bus.in_ready), 64'(0));
    d = {$urandom, $urandom};
    drive(1'b0, d, 8'hA5, 1'b0);
    head = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_held_in_ready", 64'(bus.in_ready), 64'(0));
      check("t3_stable_tag", 64'(bus.out_tag), 64'(head.tag));
      check("t3_stable_data", bus.out_data, head.data);
    end
    ready_mode = 1;
    wait_accept(1'b0, d, 8'hA5, 1'b0);
    drain("t3");

    // 4: full FIFO then continuous push and pop, then random backpressure
    set_ready(0);
    push_rand(DEPTH);
    set_ready(1);
    push_rand(10);
    set_ready(2);
    push_rand(40);
    set_ready(1);
    drain("t4");
    check_stats("t4");

    // 5: clear, saturation, clear concurrent with a DUE push
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    model_clear();
    check_stats("t5_clear");
    for (int i = 0; i < MAXC - 1; i++) push_beat(1'b0, {$urandom, $urandom}, 8'($urandom), 1'b0);
    check("t5_pre_sat", 64'(beat_count), 64'(MAXC - 1));
    for (int i = 0; i < 3; i++) push_beat(1'b0, {$urandom, $urandom}, 8'($urandom), 1'b0);
    check("t5_beat_sat", 64'(beat_count), 64'(MAXC));
    for (int i = 0; i < MAXC + 2; i++) push_beat(1'b1, {$urandom, $urandom}, 8'(i), 1'b0);
    check("t5_due_sat", 64'(due_count), 64'(MAXC));
    push_beat(1'b1, {$urandom, $urandom}, 8'h77, 1'b1);
    check("t5_clr_push_beat", 64'(beat_count), 64'(1));
    check("t5_clr_push_due", 64'(due_count), 64'(1));
    check_stats("t5_clr_push");
    drain("t5");

    // 6: reset with entries queued and a push mid-handshake
    set_ready(0);
    push_rand(3);
    set_ready(1);
    drive(1'b1, {$urandom, $urandom}, 8'h99, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_clear();
    check("t6_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("t6_rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("t6_rst_out_tag", 64'(bus.out_tag), 64'(0));
    check_stats("t6_rst");
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_beat(1'b0, 64'hCAFE_F00D_1234_5678, 8'h42, 1'b0);
    drain("t6");
    check("t6_post_tag", 64'(bus.out_tag), 64'h42);
    check_stats("t6_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
